// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle sequencer and the datapath.
// The sequencer takes the master side; the datapath (or a bench) takes the slave side.
interface multicycle_control_if #(
    parameter int unsigned RETIRE_W = 16
) ();
    logic                enable;
    logic [5:0]          opcode;

    logic                pc_write;
    logic                pc_write_cond;
    logic                iord;
    logic                mem_read;
    logic                mem_write;
    logic                ir_write;
    logic                mem_to_reg;
    logic                reg_write;
    logic                reg_dst;
    logic                alu_src_a;
    logic [1:0]          alu_src_b;
    logic [1:0]          alu_op;
    logic [1:0]          pc_source;

    logic [3:0]          state;
    logic                halted;
    logic                retire;
    logic [RETIRE_W-1:0] retire_count;

    modport master (
        input  enable, opcode,
        output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
        output mem_to_reg, reg_write, reg_dst, alu_src_a, alu_src_b, alu_op, pc_source,
        output state, halted, retire, retire_count
    );

    modport slave (
        output enable, opcode,
        input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
        input  mem_to_reg, reg_write, reg_dst, alu_src_a, alu_src_b, alu_op, pc_source,
        input  state, halted, retire, retire_count
    );
endinterface

// File: rtl/multicycle_control.sv
// Moore control sequencer for the multi-cycle datapath: fetch/decode/execute/mem/write-back,
// global stall, halt on illegal opcode and a wrapping retired-instruction counter.
module multicycle_control #(
    parameter int unsigned RETIRE_W = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    multicycle_control_if.master bus
);

    typedef enum logic [3:0] {
        StFetch     = 4'd0,
        StDecode    = 4'd1,
        StMemAddr   = 4'd2,
        StMemRead   = 4'd3,
        StMemWb     = 4'd4,
        StMemWrite  = 4'd5,
        StExecute   = 4'd6,
        StRCompl    = 4'd7,
        StBranch    = 4'd8,
        StJump      = 4'd9,
        StAddiExe   = 4'd10,
        StAddiCompl = 4'd11,
        StHalt      = 4'd15
    } state_e;

    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;
    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpAddi  = 6'h08;

    state_e              state_q, state_d;
    logic [RETIRE_W-1:0] retire_q, retire_d;

    logic       pc_write_raw, pc_write_cond_raw, mem_read_raw, mem_write_raw;
    logic       ir_write_raw, reg_write_raw;
    logic       iord_c, mem_to_reg_c, reg_dst_c, alu_src_a_c;
    logic [1:0] alu_src_b_c, alu_op_c, pc_source_c;
    logic       terminal;
    logic       gate;

    // Stall and reset both suppress every side effect; selects stay state-driven.
    assign gate = bus.enable & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StFetch;
            retire_q <= '0;
        end else begin
            state_q  <= state_d;
            retire_q <= retire_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.enable) begin
            case (state_q)
                StFetch:   state_d = StDecode;
                StDecode: begin
                    case (bus.opcode)
                        OpLw, OpSw: state_d = StMemAddr;
                        OpRtype:    state_d = StExecute;
                        OpBeq:      state_d = StBranch;
                        OpJ:        state_d = StJump;
                        OpAddi:     state_d = StAddiExe;
                        default:    state_d = StHalt;
                    endcase
                end
                StMemAddr: state_d = (bus.opcode == OpLw) ? StMemRead : StMemWrite;
                StMemRead: state_d = StMemWb;
                StExecute: state_d = StRCompl;
                StAddiExe: state_d = StAddiCompl;
                StMemWb, StMemWrite, StRCompl, StBranch, StJump, StAddiCompl:
                    state_d = StFetch;
                StHalt:    state_d = StHalt;
                default:   state_d = StHalt;
            endcase
        end
    end

    always_comb begin
        pc_write_raw      = 1'b0;
        pc_write_cond_raw = 1'b0;
        mem_read_raw      = 1'b0;
        mem_write_raw     = 1'b0;
        ir_write_raw      = 1'b0;
        reg_write_raw     = 1'b0;
        iord_c            = 1'b0;
        mem_to_reg_c      = 1'b0;
        reg_dst_c         = 1'b0;
        alu_src_a_c       = 1'b0;
        alu_src_b_c       = 2'b00;
        alu_op_c          = 2'b00;
        pc_source_c       = 2'b00;
        case (state_q)
            StFetch: begin
                mem_read_raw = 1'b1;
                ir_write_raw = 1'b1;
                pc_write_raw = 1'b1;
                alu_src_b_c  = 2'b01;
            end
            StDecode:  alu_src_b_c = 2'b11;
            StMemAddr: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = 2'b10;
            end
            StMemRead: begin
                mem_read_raw = 1'b1;
                iord_c       = 1'b1;
            end
            StMemWb: begin
                reg_write_raw = 1'b1;
                mem_to_reg_c  = 1'b1;
            end
            StMemWrite: begin
                mem_write_raw = 1'b1;
                iord_c        = 1'b1;
            end
            StExecute: begin
                alu_src_a_c = 1'b1;
                alu_op_c    = 2'b10;
            end
            StRCompl: begin
                reg_write_raw = 1'b1;
                reg_dst_c     = 1'b1;
            end
            StBranch: begin
                alu_src_a_c       = 1'b1;
                alu_op_c          = 2'b01;
                pc_write_cond_raw = 1'b1;
                pc_source_c       = 2'b01;
            end
            StJump: begin
                pc_write_raw = 1'b1;
                pc_source_c  = 2'b10;
            end
            StAddiExe: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = 2'b10;
            end
            StAddiCompl: reg_write_raw = 1'b1;
            default: ;
        endcase
    end

    assign terminal = state_q inside {StMemWb, StMemWrite, StRCompl, StBranch, StJump,
                                      StAddiCompl};

    always_comb begin
        retire_d = retire_q;
        if (terminal && bus.enable) begin
            retire_d = retire_q + RETIRE_W'(1);
        end
    end

    assign bus.pc_write      = pc_write_raw & gate;
    assign bus.pc_write_cond = pc_write_cond_raw & gate;
    assign bus.mem_read      = mem_read_raw & gate;
    assign bus.mem_write     = mem_write_raw & gate;
    assign bus.ir_write      = ir_write_raw & gate;
    assign bus.reg_write     = reg_write_raw & gate;
    assign bus.iord          = iord_c;
    assign bus.mem_to_reg    = mem_to_reg_c;
    assign bus.reg_dst       = reg_dst_c;
    assign bus.alu_src_a     = alu_src_a_c;
    assign bus.alu_src_b     = alu_src_b_c;
    assign bus.alu_op        = alu_op_c;
    assign bus.pc_source     = pc_source_c;
    assign bus.state         = state_q;
    assign bus.halted        = (state_q == StHalt);
    assign bus.retire        = terminal & gate;
    assign bus.retire_count  = retire_q;

endmodule
